// File: rtl/ixu_sched_queue.sv
`default_nettype none
// =============================================================================
// ixu_sched_queue : age-ordered, fully compacting issue queue, dual SC/MC issue
// Revision 1.0
// =============================================================================
module ixu_sched_queue #(
  parameter int DEPTH    = 10,
  parameter int TAG_W    = 6,
  parameter int ROB_W    = 6,
  parameter int WK_PORTS = 4
) (
  input  logic                           core_clock_i,
  input  logic                           core_reset_ni,
  input  logic                           core_flush_i,

  input  logic                           p0_vld_i,
  input  logic [TAG_W-1:0]               p0_rs1_i,
  input  logic [TAG_W-1:0]               p0_rs2_i,
  input  logic [ROB_W-1:0]               p0_rob_i,
  input  logic                           p0_rs1_vld_i,
  input  logic                           p0_rs2_vld_i,
  input  logic                           p0_rs1_rdy_i,
  input  logic                           p0_rs2_rdy_i,
  input  logic                           p0_restrict_to_sc_i,
  input  logic                           p0_restrict_to_mc_i,
  output logic                           p0_busy_o,

  input  logic                           p1_vld_i,
  input  logic [TAG_W-1:0]               p1_rs1_i,
  input  logic [TAG_W-1:0]               p1_rs2_i,
  input  logic [ROB_W-1:0]               p1_rob_i,
  input  logic                           p1_rs1_vld_i,
  input  logic                           p1_rs2_vld_i,
  input  logic                           p1_rs1_rdy_i,
  input  logic                           p1_rs2_rdy_i,
  input  logic                           p1_restrict_to_sc_i,
  input  logic                           p1_restrict_to_mc_i,
  output logic                           p1_busy_o,

  input  logic [WK_PORTS*TAG_W-1:0]      wk_tag_i,
  input  logic [WK_PORTS-1:0]            wk_vld_i,

  input  logic                           sc_busy_i,
  input  logic                           mc_busy_i,
  output logic                           sc_vld_o,
  output logic                           mc_vld_o,
  output logic [2*TAG_W+ROB_W-1:0]       sc_data_o,
  output logic [2*TAG_W+ROB_W-1:0]       mc_data_o,

  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int DAT_W = 2*TAG_W + ROB_W;

  typedef struct packed {
    logic [TAG_W-1:0] rs2;
    logic [TAG_W-1:0] rs1;
    logic [ROB_W-1:0] rob;
    logic             rdy1;
    logic             rdy2;
    logic             only_sc;
    logic             only_mc;
  } entry_t;

  entry_t             entry_q [DEPTH];
  entry_t             entry_d [DEPTH];
  entry_t             cur     [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               sc_vld_q, mc_vld_q;
  logic [DAT_W-1:0]   sc_data_q, mc_data_q, sc_data_d, mc_data_d;

  logic [DEPTH-1:0]   ready, mc_sel, sc_sel, survive;
  logic               mc_found, sc_found;
  logic [CNT_W-1:0]   pos [DEPTH];
  logic [CNT_W-1:0]   n_surv, slot0, slot1;
  logic               acc0, acc1;
  entry_t             new0, new1;

  function automatic logic wk_hit(input logic [TAG_W-1:0]          tag,
                                  input logic [WK_PORTS*TAG_W-1:0] tags,
                                  input logic [WK_PORTS-1:0]       vld);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WK_PORTS; p++)
      if (vld[p] && (tags[p*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    return hit;
  endfunction

  // Busy depends on registered occupancy only, so slots freed by this cycle's
  // issue are never reused in the same cycle.
  assign p0_busy_o = (count_q == CNT_W'(DEPTH));
  assign p1_busy_o = (count_q >= CNT_W'(DEPTH-1));

  assign acc0 = p0_vld_i & ~p0_busy_o & ~core_flush_i;
  assign acc1 = p1_vld_i & ~p1_busy_o & ~core_flush_i;

  always_comb begin
    new0.rs2     = p0_rs2_i;
    new0.rs1     = p0_rs1_i;
    new0.rob     = p0_rob_i;
    new0.rdy1    = ~p0_rs1_vld_i | p0_rs1_rdy_i | wk_hit(p0_rs1_i, wk_tag_i, wk_vld_i);
    new0.rdy2    = ~p0_rs2_vld_i | p0_rs2_rdy_i | wk_hit(p0_rs2_i, wk_tag_i, wk_vld_i);
    new0.only_sc = p0_restrict_to_sc_i;
    new0.only_mc = p0_restrict_to_mc_i;
    new1.rs2     = p1_rs2_i;
    new1.rs1     = p1_rs1_i;
    new1.rob     = p1_rob_i;
    new1.rdy1    = ~p1_rs1_vld_i | p1_rs1_rdy_i | wk_hit(p1_rs1_i, wk_tag_i, wk_vld_i);
    new1.rdy2    = ~p1_rs2_vld_i | p1_rs2_rdy_i | wk_hit(p1_rs2_i, wk_tag_i, wk_vld_i);
    new1.only_sc = p1_restrict_to_sc_i;
    new1.only_mc = p1_restrict_to_mc_i;
  end

  // Resident entries see this cycle's wakeups before selection.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cur[i]      = entry_q[i];
      cur[i].rdy1 = entry_q[i].rdy1 | wk_hit(entry_q[i].rs1, wk_tag_i, wk_vld_i);
      cur[i].rdy2 = entry_q[i].rdy2 | wk_hit(entry_q[i].rs2, wk_tag_i, wk_vld_i);
      ready[i]    = vld_q[i] & cur[i].rdy1 & cur[i].rdy2;
    end
  end

  // MC picks first; SC takes the oldest remaining candidate.
  always_comb begin
    mc_sel    = '0;
    sc_sel    = '0;
    mc_found  = 1'b0;
    sc_found  = 1'b0;
    mc_data_d = '0;
    sc_data_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!mc_found && ready[i] && !cur[i].only_sc && !mc_busy_i && !core_flush_i) begin
        mc_sel[i] = 1'b1;
        mc_found  = 1'b1;
        mc_data_d = {cur[i].rs2, cur[i].rs1, cur[i].rob};
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!sc_found && ready[i] && !cur[i].only_mc && !mc_sel[i] && !sc_busy_i && !core_flush_i) begin
        sc_sel[i] = 1'b1;
        sc_found  = 1'b1;
        sc_data_d = {cur[i].rs2, cur[i].rs1, cur[i].rob};
      end
    end
  end

  always_comb begin
    n_surv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      survive[i] = vld_q[i] & ~mc_sel[i] & ~sc_sel[i];
      pos[i]     = n_surv;
      n_surv     = n_surv + CNT_W'(survive[i]);
    end
  end

  assign slot0   = n_surv;
  assign slot1   = n_surv + CNT_W'(acc0);
  assign count_d = core_flush_i ? '0 : (n_surv + CNT_W'(acc0) + CNT_W'(acc1));

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      entry_d[j] = entry_q[j];
      for (int i = 0; i < DEPTH; i++)
        if (survive[i] && (pos[i] == CNT_W'(j))) entry_d[j] = cur[i];
      if (acc0 && (slot0 == CNT_W'(j))) entry_d[j] = new0;
      if (acc1 && (slot1 == CNT_W'(j))) entry_d[j] = new1;
      vld_d[j] = (CNT_W'(j) < count_d);
    end
  end

  always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
    if (!core_reset_ni) begin
      vld_q     <= '0;
      count_q   <= '0;
      sc_vld_q  <= 1'b0;
      mc_vld_q  <= 1'b0;
      sc_data_q <= '0;
      mc_data_q <= '0;
    end else begin
      vld_q    <= vld_d;
      count_q  <= count_d;
      sc_vld_q <= sc_found;
      mc_vld_q <= mc_found;
      if (sc_found) sc_data_q <= sc_data_d;
      if (mc_found) mc_data_q <= mc_data_d;
    end
  end

  always_ff @(posedge core_clock_i) begin
    entry_q <= entry_d;
  end

  assign sc_vld_o  = sc_vld_q;
  assign mc_vld_o  = mc_vld_q;
  assign sc_data_o = sc_data_q;
  assign mc_data_o = mc_data_q;
  assign count_o   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ixu_sched_queue.sv
`default_nettype none
// Directed self-checking bench for ixu_sched_queue (DEPTH=10, TAG_W=6, ROB_W=6).
module tb_ixu_sched_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic        p0_vld, p0_rs1_vld, p0_rs2_vld, p0_rs1_rdy, p0_rs2_rdy, p0_osc, p0_omc, p0_busy;
  logic [5:0]  p0_rs1, p0_rs2, p0_rob;
  logic        p1_vld, p1_rs1_vld, p1_rs2_vld, p1_rs1_rdy, p1_rs2_rdy, p1_osc, p1_omc, p1_busy;
  logic [5:0]  p1_rs1, p1_rs2, p1_rob;
  logic [23:0] wk_tag;
  logic [3:0]  wk_vld;
  logic        sc_busy, mc_busy, sc_vld, mc_vld;
  logic [17:0] sc_data, mc_data;
  logic [3:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  ixu_sched_queue #(.DEPTH(10), .TAG_W(6), .ROB_W(6), .WK_PORTS(4)) dut (
    .core_clock_i(clk), .core_reset_ni(rst_n), .core_flush_i(flush),
    .p0_vld_i(p0_vld), .p0_rs1_i(p0_rs1), .p0_rs2_i(p0_rs2), .p0_rob_i(p0_rob),
    .p0_rs1_vld_i(p0_rs1_vld), .p0_rs2_vld_i(p0_rs2_vld),
    .p0_rs1_rdy_i(p0_rs1_rdy), .p0_rs2_rdy_i(p0_rs2_rdy),
    .p0_restrict_to_sc_i(p0_osc), .p0_restrict_to_mc_i(p0_omc), .p0_busy_o(p0_busy),
    .p1_vld_i(p1_vld), .p1_rs1_i(p1_rs1), .p1_rs2_i(p1_rs2), .p1_rob_i(p1_rob),
    .p1_rs1_vld_i(p1_rs1_vld), .p1_rs2_vld_i(p1_rs2_vld),
    .p1_rs1_rdy_i(p1_rs1_rdy), .p1_rs2_rdy_i(p1_rs2_rdy),
    .p1_restrict_to_sc_i(p1_osc), .p1_restrict_to_mc_i(p1_omc), .p1_busy_o(p1_busy),
    .wk_tag_i(wk_tag), .wk_vld_i(wk_vld),
    .sc_busy_i(sc_busy), .mc_busy_i(mc_busy),
    .sc_vld_o(sc_vld), .mc_vld_o(mc_vld), .sc_data_o(sc_data), .mc_data_o(mc_data),
    .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dat(input logic [5:0] rs2, input logic [5:0] rs1,
                                      input logic [5:0] rob);
    return {14'd0, rs2, rs1, rob};
  endfunction

  task automatic idle();
    flush = 0; p0_vld = 0; p1_vld = 0; wk_tag = '0; wk_vld = '0;
  endtask

  task automatic set_p0(input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rob,
                        input logic v1, input logic v2, input logic r1, input logic r2,
                        input logic osc, input logic omc);
    p0_vld = 1; p0_rs1 = rs1; p0_rs2 = rs2; p0_rob = rob;
    p0_rs1_vld = v1; p0_rs2_vld = v2; p0_rs1_rdy = r1; p0_rs2_rdy = r2;
    p0_osc = osc; p0_omc = omc;
  endtask

  task automatic set_p1(input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rob,
                        input logic v1, input logic v2, input logic r1, input logic r2,
                        input logic osc, input logic omc);
    p1_vld = 1; p1_rs1 = rs1; p1_rs2 = rs2; p1_rob = rob;
    p1_rs1_vld = v1; p1_rs2_vld = v2; p1_rs1_rdy = r1; p1_rs2_rdy = r2;
    p1_osc = osc; p1_omc = omc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    sc_busy = 0; mc_busy = 0;
    set_p0(0, 0, 0, 0, 0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Reset state
    repeat (2) step();
    chk("rst_count", 32'(count), 0);
    chk("rst_sc_vld", 32'(sc_vld), 0);
    chk("rst_mc_vld", 32'(mc_vld), 0);
    chk("rst_sc_data", 32'(sc_data), 0);
    chk("rst_mc_data", 32'(mc_data), 0);
    chk("rst_p0_busy", 32'(p0_busy), 0);
    chk("rst_p1_busy", 32'(p1_busy), 0);
    rst_n = 1;

    // Single ready entry issues on MC two edges after enqueue
    set_p0(5, 7, 3, 1, 1, 1, 1, 0, 0);
    step(); idle();
    chk("enq_count", 32'(count), 1);
    chk("enq_no_early_mc", 32'(mc_vld), 0);
    chk("enq_no_early_sc", 32'(sc_vld), 0);
    step();
    chk("iss_mc_vld", 32'(mc_vld), 1);
    chk("iss_mc_data", 32'(mc_data), dat(7, 5, 3));
    chk("iss_sc_vld", 32'(sc_vld), 0);
    chk("iss_count", 32'(count), 0);
    step();
    chk("idle_mc_vld", 32'(mc_vld), 0);
    chk("hold_mc_data", 32'(mc_data), dat(7, 5, 3));

    // Wakeup in the enqueue cycle marks the operand ready
    set_p0(20, 21, 1, 1, 0, 0, 0, 0, 0);
    wk_tag = 24'd20; wk_vld = 4'b0001;
    step(); idle();
    step();
    chk("enqwk_mc_vld", 32'(mc_vld), 1);
    chk("enqwk_mc_data", 32'(mc_data), dat(21, 20, 1));

    // Fill to 9 entries waiting on rs1 only
    for (int k = 0; k < 9; k++) begin
      set_p0(6'(10 + k), 6'(30 + k), 6'(k), 1, 0, 0, 0, 0, 0);
      step();
    end
    idle();
    chk("fill9_count", 32'(count), 9);
    chk("fill9_p0_busy", 32'(p0_busy), 0);
    chk("fill9_p1_busy", 32'(p1_busy), 1);
    chk("fill9_mc_vld", 32'(mc_vld), 0);
    set_p0(19, 39, 9, 1, 0, 0, 0, 0, 0);
    set_p1(25, 45, 25, 1, 0, 0, 0, 0, 0);
    step(); idle();
    chk("full_count", 32'(count), 10);
    chk("full_p0_busy", 32'(p0_busy), 1);
    chk("full_p1_busy", 32'(p1_busy), 1);
    // Wake entry 4 through port 2 while a p0 enqueue is offered into a full queue
    wk_tag = 24'd14 << 12; wk_vld = 4'b0100;
    set_p0(26, 46, 26, 1, 0, 0, 0, 0, 0);
    step(); idle();
    chk("wk4_mc_vld", 32'(mc_vld), 1);
    chk("wk4_mc_data", 32'(mc_data), dat(34, 14, 4));
    chk("wk4_sc_vld", 32'(sc_vld), 0);
    chk("wk4_count", 32'(count), 9);
    // Wake oldest and youngest: MC gets oldest, SC gets the other
    wk_tag = (24'd19 << 6) | 24'd10; wk_vld = 4'b0011;
    step(); idle();
    chk("dual_mc_vld", 32'(mc_vld), 1);
    chk("dual_mc_data", 32'(mc_data), dat(30, 10, 0));
    chk("dual_sc_vld", 32'(sc_vld), 1);
    chk("dual_sc_data", 32'(sc_data), dat(39, 19, 9));
    chk("dual_count", 32'(count), 7);

    // Flush beats wakeup and enqueue
    flush = 1; wk_tag = 24'd11; wk_vld = 4'b0001;
    set_p0(50, 51, 50, 1, 1, 1, 1, 0, 0);
    set_p1(52, 53, 52, 1, 1, 1, 1, 0, 0);
    step(); idle();
    chk("flush_count", 32'(count), 0);
    chk("flush_sc_vld", 32'(sc_vld), 0);
    chk("flush_mc_vld", 32'(mc_vld), 0);
    repeat (2) step();
    chk("postflush_sc_vld", 32'(sc_vld), 0);
    chk("postflush_mc_vld", 32'(mc_vld), 0);
    chk("postflush_count", 32'(count), 0);

    // Restricted entries: A sc-only (older), B mc-only, MC busy for one cycle
    set_p0(1, 2, 40, 0, 0, 0, 0, 1, 0);
    set_p1(3, 4, 41, 0, 0, 0, 0, 0, 1);
    step(); idle();
    chk("restr_count", 32'(count), 2);
    mc_busy = 1;
    step();
    chk("restrA_sc_vld", 32'(sc_vld), 1);
    chk("restrA_sc_data", 32'(sc_data), dat(2, 1, 40));
    chk("restrA_mc_vld", 32'(mc_vld), 0);
    chk("restrA_count", 32'(count), 1);
    mc_busy = 0;
    step();
    chk("restrB_mc_vld", 32'(mc_vld), 1);
    chk("restrB_mc_data", 32'(mc_data), dat(4, 3, 41));
    chk("restrB_sc_vld", 32'(sc_vld), 0);
    chk("restrB_count", 32'(count), 0);

    // MC busy: two unrestricted entries drain one per cycle on SC, oldest first
    set_p0(5, 6, 42, 1, 1, 1, 1, 0, 0);
    set_p1(7, 8, 43, 1, 1, 1, 1, 0, 0);
    step(); idle();
    mc_busy = 1;
    step();
    chk("mcb1_sc_vld", 32'(sc_vld), 1);
    chk("mcb1_sc_data", 32'(sc_data), dat(6, 5, 42));
    chk("mcb1_mc_vld", 32'(mc_vld), 0);
    chk("mcb1_count", 32'(count), 1);
    step();
    chk("mcb2_sc_vld", 32'(sc_vld), 1);
    chk("mcb2_sc_data", 32'(sc_data), dat(8, 7, 43));
    chk("mcb2_mc_vld", 32'(mc_vld), 0);
    chk("mcb2_count", 32'(count), 0);
    mc_busy = 0;

    // Asynchronous reset while mc_vld is high
    set_p0(9, 10, 44, 1, 1, 1, 1, 0, 0);
    step(); idle();
    set_p0(13, 14, 47, 0, 0, 0, 0, 0, 0);
    step(); idle();
    chk("prerst_mc_vld", 32'(mc_vld), 1);
    chk("prerst_count", 32'(count), 1);
    #2 rst_n = 0;
    #1;
    chk("arst_mc_vld", 32'(mc_vld), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_mc_data", 32'(mc_data), 0);
    #1 rst_n = 1;
    set_p0(11, 12, 45, 1, 1, 1, 1, 0, 0);
    step(); idle();
    chk("postrst_count", 32'(count), 1);
    step();
    chk("postrst_mc_vld", 32'(mc_vld), 1);
    chk("postrst_mc_data", 32'(mc_data), dat(12, 11, 45));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
